// File: rtl/bias_addr_generate_if.sv
// Bias AGU port bundle: loop bounds and PE strobe in, bias-buffer read request out.
interface bias_addr_generate_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 8
);
  logic          calculate_enble;
  logic [4:0]    part_num;
  logic [7:0]    out_piece;
  logic [AW-1:0] addr_start_b;
  logic          pe_out_en;

  logic [AW-1:0] o_b_addr;
  logic          o_rd_en;
  logic [CW-1:0] o_part_num;
  logic [CW-1:0] o_out_piece;
  logic          o_r_part_end;

  modport master (
    output calculate_enble, part_num, out_piece, addr_start_b, pe_out_en,
    input  o_b_addr, o_rd_en, o_part_num, o_out_piece, o_r_part_end
  );

  modport slave (
    input  calculate_enble, part_num, out_piece, addr_start_b, pe_out_en,
    output o_b_addr, o_rd_en, o_part_num, o_out_piece, o_r_part_end
  );
endinterface

// File: rtl/bias_addr_generate.sv
// Bias-buffer address generator: one read per PE output-valid event, the bias
// address advancing once per output piece (reused across all its parts).
module bias_addr_generate #(
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bias_addr_generate_if.slave  bus
);

  localparam int unsigned PW = 5;
  localparam int unsigned NW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] parts_m1_q, parts_m1_d;
  logic [NW-1:0] pieces_m1_q, pieces_m1_d;
  logic [AW-1:0] start_q, start_d;
  logic [PW-1:0] part_cnt_q, part_cnt_d;
  logic [NW-1:0] piece_cnt_q, piece_cnt_d;

  logic [AW-1:0] b_addr_q, b_addr_d;
  logic          rd_en_q, rd_en_d;
  logic [CW-1:0] part_num_q, part_num_d;
  logic [CW-1:0] out_piece_q, out_piece_d;
  logic          part_end_q, part_end_d;

  logic          last_part;
  logic          last_piece;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      parts_m1_q  <= '0;
      pieces_m1_q <= '0;
      start_q     <= '0;
      part_cnt_q  <= '0;
      piece_cnt_q <= '0;
      b_addr_q    <= '0;
      rd_en_q     <= 1'b0;
      part_num_q  <= '0;
      out_piece_q <= '0;
      part_end_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      parts_m1_q  <= parts_m1_d;
      pieces_m1_q <= pieces_m1_d;
      start_q     <= start_d;
      part_cnt_q  <= part_cnt_d;
      piece_cnt_q <= piece_cnt_d;
      b_addr_q    <= b_addr_d;
      rd_en_q     <= rd_en_d;
      part_num_q  <= part_num_d;
      out_piece_q <= out_piece_d;
      part_end_q  <= part_end_d;
    end
  end

  // Bounds are held as count-1 so a zero request collapses to a single step.
  always_comb begin
    state_d     = state_q;
    parts_m1_d  = parts_m1_q;
    pieces_m1_d = pieces_m1_q;
    start_d     = start_q;
    part_cnt_d  = part_cnt_q;
    piece_cnt_d = piece_cnt_q;
    b_addr_d    = b_addr_q;
    rd_en_d     = 1'b0;
    part_num_d  = part_num_q;
    out_piece_d = out_piece_q;
    part_end_d  = 1'b0;
    last_part   = (part_cnt_q == parts_m1_q);
    last_piece  = (piece_cnt_q == pieces_m1_q);

    if (bus.calculate_enble) begin
      // Start (or restart) wins over any coincident event.
      parts_m1_d  = (bus.part_num == '0) ? '0 : bus.part_num - PW'(1);
      pieces_m1_d = (bus.out_piece == '0) ? '0 : bus.out_piece - NW'(1);
      start_d     = bus.addr_start_b;
      part_cnt_d  = '0;
      piece_cnt_d = '0;
      state_d     = RUN;
    end else if ((state_q == RUN) && bus.pe_out_en) begin
      rd_en_d     = 1'b1;
      b_addr_d    = start_q + AW'(piece_cnt_q);
      part_num_d  = CW'(part_cnt_q);
      out_piece_d = CW'(piece_cnt_q);
      part_end_d  = last_part;
      if (last_part) begin
        part_cnt_d  = '0;
        piece_cnt_d = piece_cnt_q + NW'(1);
        if (last_piece) begin
          state_d = IDLE;
        end
      end else begin
        part_cnt_d = part_cnt_q + PW'(1);
      end
    end
  end

  assign bus.o_b_addr     = b_addr_q;
  assign bus.o_rd_en      = rd_en_q;
  assign bus.o_part_num   = part_num_q;
  assign bus.o_out_piece  = out_piece_q;
  assign bus.o_r_part_end = part_end_q;

endmodule

// File: tb/tb_bias_addr_generate.sv
// Self-checking bench for bias_addr_generate: directed scenarios plus randomized
// runs against a list-based model of the expected read sequence.
module tb_bias_addr_generate;

  logic clk;
  logic rst;

  bias_addr_generate_if #(.AW(8), .CW(8)) bus ();

  bias_addr_generate #(.AW(8), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] part;
    logic [7:0] piece;
    logic       pend;
  } rec_t;

  rec_t       m_q[$];
  bit         m_run;
  logic       exp_rd, exp_end;
  logic [7:0] exp_addr, exp_part, exp_piece;
  int         n_checks;
  int         n_fail;

  // Expected reads of a run, enumerated piece-major, part-minor.
  function automatic void model_start(int parts, int pieces, int start);
    rec_t r;
    int p, n;
    p = (parts == 0) ? 1 : parts;
    n = (pieces == 0) ? 1 : pieces;
    m_q.delete();
    for (int pc = 0; pc < n; pc++) begin
      for (int pt = 0; pt < p; pt++) begin
        r.addr  = 8'((start + pc) % 256);
        r.part  = 8'(pt);
        r.piece = 8'(pc);
        r.pend  = (pt == p - 1);
        m_q.push_back(r);
      end
    end
    m_run = 1'b1;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_run     = 1'b0;
    exp_rd    = 1'b0;
    exp_end   = 1'b0;
    exp_addr  = '0;
    exp_part  = '0;
    exp_piece = '0;
  endfunction

  // Called at a falling edge: drives one cycle, ends at the next falling edge.
  task automatic step(input logic cal, input logic pe);
    rec_t r;
    bus.calculate_enble = cal;
    bus.pe_out_en       = pe;
    exp_rd  = 1'b0;
    exp_end = 1'b0;
    if (cal) begin
      model_start(int'(bus.part_num), int'(bus.out_piece), int'(bus.addr_start_b));
    end else if (m_run && pe) begin
      r = m_q.pop_front();
      exp_rd    = 1'b1;
      exp_end   = r.pend;
      exp_addr  = r.addr;
      exp_part  = r.part;
      exp_piece = r.piece;
      if (m_q.size() == 0) m_run = 1'b0;
    end
    @(negedge clk);
    bus.calculate_enble = 1'b0;
    bus.pe_out_en       = 1'b0;
  endtask

  task automatic set_bounds(input int parts, input int pieces, input int start);
    bus.part_num     = 5'(parts);
    bus.out_piece    = 8'(pieces);
    bus.addr_start_b = 8'(start);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got rd=%b end=%b addr=%0d part=%0d piece=%0d, want all 0",
               bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece);
    end
    @(negedge clk);
    rst = 1'b1;
    set_bounds(3, 3, 5);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    n_checks++;
    if ({bus.o_rd_en, bus.o_b_addr, bus.o_part_num} !== {1'b1, 8'd5, 8'd2}) begin
      n_fail++;
      $display("FAIL reset_prerun: got rd=%b addr=%0d part=%0d, want rd=1 addr=5 part=2",
               bus.o_rd_en, bus.o_b_addr, bus.o_part_num);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_async: got rd=%b end=%b addr=%0d part=%0d piece=%0d, want all 0",
               bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      n_checks++;
      if ({bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece} !== 27'd0) begin
        n_fail++;
        $display("FAIL reset_idle_ignore[%0d]: got rd=%b addr=%0d part=%0d, want all 0",
                 i, bus.o_rd_en, bus.o_b_addr, bus.o_part_num);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] want_addr, want_part;
    logic       want_rd, want_end;
    set_bounds(3, 3, 0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1);
      want_rd   = (i < 9);
      want_addr = (i < 9) ? 8'(i / 3) : 8'd2;
      want_part = (i < 9) ? 8'(i % 3) : 8'd2;
      want_end  = (i < 9) && (i % 3 == 2);
      n_checks++;
      if ({bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece} !==
          {want_rd, want_end, want_addr, want_part, want_addr}) begin
        n_fail++;
        $display("FAIL basic_pulse[%0d]: got rd=%b end=%b addr=%0d part=%0d piece=%0d, want rd=%b end=%b addr=%0d part=%0d piece=%0d",
                 i + 1, bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece,
                 want_rd, want_end, want_addr, want_part, want_addr);
      end
      for (int k = 0; k < 2; k++) begin
        step(1'b0, 1'b0);
        n_checks++;
        if ({bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num} !==
            {1'b0, 1'b0, want_addr, want_part}) begin
          n_fail++;
          $display("FAIL basic_gap[%0d.%0d]: got rd=%b end=%b addr=%0d part=%0d, want rd=0 end=0 addr=%0d part=%0d",
                   i + 1, k, bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, want_addr, want_part);
        end
      end
    end
  endtask

  task automatic test_wrap();
    set_bounds(1, 4, 254);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      n_checks++;
      if ({bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece} !==
          {1'b1, 1'b1, 8'(254 + i), 8'd0, 8'(i)}) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got rd=%b end=%b addr=%0d part=%0d piece=%0d, want rd=1 end=1 addr=%0d part=0 piece=%0d",
                 i, bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece,
                 8'(254 + i), i);
      end
    end
    step(1'b0, 1'b1);
    n_checks++;
    if (bus.o_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done: got rd=%b, want 0", bus.o_rd_en);
    end
  endtask

  task automatic test_zero_latch();
    int reads;
    int start;
    reads = 0;
    start = int'($urandom_range(0, 255));
    set_bounds(0, 0, start);
    step(1'b1, 1'b0);
    set_bounds(7, 9, int'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      if (bus.o_rd_en === 1'b1) reads++;
      n_checks++;
      if ({bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece} !==
          {exp_rd, exp_end, exp_addr, exp_part, exp_piece}) begin
        n_fail++;
        $display("FAIL zero_bounds[%0d]: got rd=%b end=%b addr=%0d part=%0d piece=%0d, want rd=%b end=%b addr=%0d part=%0d piece=%0d",
                 i, bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece,
                 exp_rd, exp_end, exp_addr, exp_part, exp_piece);
      end
    end
    n_checks++;
    if (reads != 1) begin
      n_fail++;
      $display("FAIL zero_bounds_count: got %0d reads, want 1", reads);
    end
  endtask

  task automatic test_restart();
    set_bounds(3, 3, 10);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    n_checks++;
    if ({bus.o_b_addr, bus.o_part_num, bus.o_out_piece} !== {8'd11, 8'd0, 8'd1}) begin
      n_fail++;
      $display("FAIL restart_before: got addr=%0d part=%0d piece=%0d, want addr=11 part=0 piece=1",
               bus.o_b_addr, bus.o_part_num, bus.o_out_piece);
    end
    set_bounds(2, 2, 100);
    step(1'b1, 1'b1);
    n_checks++;
    if (bus.o_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_drop: got rd=%b, want 0", bus.o_rd_en);
    end
    step(1'b0, 1'b1);
    n_checks++;
    if ({bus.o_rd_en, bus.o_b_addr, bus.o_part_num, bus.o_out_piece} !== {1'b1, 8'd100, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL restart_first: got rd=%b addr=%0d part=%0d piece=%0d, want rd=1 addr=100 part=0 piece=0",
               bus.o_rd_en, bus.o_b_addr, bus.o_part_num, bus.o_out_piece);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      n_checks++;
      if ({bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece} !==
          {exp_rd, exp_end, exp_addr, exp_part, exp_piece}) begin
        n_fail++;
        $display("FAIL restart_seq[%0d]: got rd=%b end=%b addr=%0d part=%0d piece=%0d, want rd=%b end=%b addr=%0d part=%0d piece=%0d",
                 i, bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece,
                 exp_rd, exp_end, exp_addr, exp_part, exp_piece);
      end
    end
  endtask

  task automatic test_random();
    logic cal, pe;
    for (int run = 0; run < 20; run++) begin
      set_bounds(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 255)));
      step(1'b1, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 100; c++) begin
        set_bounds(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        if (($urandom_range(0, 39) == 0)) set_bounds(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                                                      int'($urandom_range(0, 255)));
        cal = ($urandom_range(0, 59) == 0);
        pe  = 1'($urandom_range(0, 1));
        step(cal, pe);
        n_checks++;
        if ({bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece} !==
            {exp_rd, exp_end, exp_addr, exp_part, exp_piece}) begin
          n_fail++;
          $display("FAIL random[%0d.%0d]: got rd=%b end=%b addr=%0d part=%0d piece=%0d, want rd=%b end=%b addr=%0d part=%0d piece=%0d",
                   run, c, bus.o_rd_en, bus.o_r_part_end, bus.o_b_addr, bus.o_part_num, bus.o_out_piece,
                   exp_rd, exp_end, exp_addr, exp_part, exp_piece);
        end
      end
    end
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    clk                 = 1'b0;
    rst                 = 1'b0;
    bus.calculate_enble = 1'b0;
    bus.pe_out_en       = 1'b0;
    set_bounds(0, 0, 0);
    model_reset();
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_latch();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
